rr_lock_arbiter: RTL

- Four-requester round-robin arbiter that shares one downstream resource, e.g. a 4-bit priority-encoded datapath or shared bus.
- Built around a rotating priority encoder. Index 0 has highest priority after reset, matching the team's priority-encoder convention.
- A grant is locked to its owner until the owner releases or a hold timeout forces hand-over.
- Registered outputs; sits between requesting units and the shared resource mux select.

---
 rtl/rr_lock_arbiter_pkg.sv | 20 ++
 rtl/rr_lock_arbiter_priority_encoder.sv | 30 +++
 rtl/rr_lock_arbiter.sv | 97 +++++++++
 3 files changed

// File: rtl/rr_lock_arbiter_pkg.sv
// Shared definitions for the four-requester round-robin lock arbiter.
// Holds the requester count, the index width, the FSM state type and the one-hot helper.
package rr_lock_arbiter_pkg;

  localparam int NUM_REQ = 4;
  localparam int IDX_W   = 2;

  typedef enum logic {
    IDLE,
    GRANT
  } state_t;

  function automatic logic [NUM_REQ-1:0] onehot(input logic [IDX_W-1:0] idx);
    logic [NUM_REQ-1:0] vec;
    vec      = '0;
    vec[idx] = 1'b1;
    return vec;
  endfunction

endpackage

// File: rtl/rr_lock_arbiter_priority_encoder.sv
// Rotating priority encoder: the first set request at or after ptr wins (cyclic scan).
// The requests are rotated so ptr lands on bit 0, encoded with fixed priority, and then ptr is added back.
module rr_priority_encoder
  import rr_lock_arbiter_pkg::*;
(
  input  logic [NUM_REQ-1:0] req,
  input  logic [IDX_W-1:0]   ptr,
  output logic [IDX_W-1:0]   idx,
  output logic               any
);

  logic [2*NUM_REQ-1:0] req_dbl;
  logic [NUM_REQ-1:0]   req_rot;
  logic [IDX_W-1:0]     pos;

  assign req_dbl = {req, req};
  assign req_rot = NUM_REQ'(req_dbl >> ptr);

  // The loop runs from high to low, so the lowest set bit is the last one written and wins.
  always_comb begin
    pos = '0;
    for (int i = NUM_REQ - 1; i >= 0; i--) begin
      if (req_rot[i]) pos = IDX_W'(i);
    end
  end

  assign idx = pos + ptr;
  assign any = |req;

endmodule

// File: rtl/rr_lock_arbiter.sv
// Round-robin arbiter with a locked grant. The owner keeps the grant until it drops its request,
// or until a hold timeout hands the grant to the next waiting requester.
module rr_lock_arbiter
  import rr_lock_arbiter_pkg::*;
#(
  parameter int MAX_HOLD = 8,
  parameter int CNT_W    = ($clog2(MAX_HOLD + 1) < 1) ? 1 : $clog2(MAX_HOLD + 1)
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic [NUM_REQ-1:0] req,
  output logic [NUM_REQ-1:0] gnt,
  output logic [IDX_W-1:0]   gnt_idx,
  output logic               gnt_valid,
  output logic               preempt
);

  localparam bit               TIMEOUT_EN = (MAX_HOLD != 0);
  localparam logic [CNT_W-1:0] HOLD_LAST  = CNT_W'(MAX_HOLD - 1);

  state_t             state_reg;
  logic [IDX_W-1:0]   ptr_reg;
  logic [CNT_W-1:0]   hold_cnt_reg;

  logic [NUM_REQ-1:0] others;
  logic [IDX_W-1:0]   next_base;
  logic [NUM_REQ-1:0] enc_req;
  logic [IDX_W-1:0]   enc_ptr;
  logic [IDX_W-1:0]   sel_idx;
  logic               sel_any;

  assign others    = req & ~gnt;
  assign next_base = gnt_idx + IDX_W'(1);

  // While IDLE, scan all requests from ptr. While a grant is held, only the contenders are scanned, starting after the owner.
  assign enc_req = (state_reg == GRANT) ? others : req;
  assign enc_ptr = (state_reg == GRANT) ? next_base : ptr_reg;

  rr_priority_encoder u_enc (
    .req (enc_req),
    .ptr (enc_ptr),
    .idx (sel_idx),
    .any (sel_any)
  );

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_reg    <= IDLE;
      gnt          <= '0;
      gnt_idx      <= '0;
      gnt_valid    <= 1'b0;
      preempt      <= 1'b0;
      ptr_reg      <= '0;
      hold_cnt_reg <= '0;
    end else begin
      preempt <= 1'b0;
      case (state_reg)
        IDLE: begin
          if (sel_any) begin
            state_reg    <= GRANT;
            gnt          <= onehot(sel_idx);
            gnt_idx      <= sel_idx;
            gnt_valid    <= 1'b1;
            hold_cnt_reg <= '0;
          end
        end
        GRANT: begin
          if (!req[gnt_idx]) begin
            ptr_reg      <= next_base;
            hold_cnt_reg <= '0;
            if (sel_any) begin
              gnt     <= onehot(sel_idx);
              gnt_idx <= sel_idx;
            end else begin
              state_reg <= IDLE;
              gnt       <= '0;
              gnt_idx   <= '0;
              gnt_valid <= 1'b0;
            end
          end else if (TIMEOUT_EN && sel_any && hold_cnt_reg == HOLD_LAST) begin
            ptr_reg      <= next_base;
            hold_cnt_reg <= '0;
            gnt          <= onehot(sel_idx);
            gnt_idx      <= sel_idx;
            preempt      <= 1'b1;
          end else if (!sel_any || !TIMEOUT_EN) begin
            hold_cnt_reg <= '0;
          end else if (hold_cnt_reg != HOLD_LAST) begin
            hold_cnt_reg <= hold_cnt_reg + CNT_W'(1);
          end
        end
        default: state_reg <= IDLE;
      endcase
    end
  end

endmodule
